// File: rtl/ntt_coeff_loader_if.sv
// OBI-style request/response bus between the coefficient loader and a memory.
// One instance per port; the loader drives the master side.
interface ntt_coeff_loader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ntt_coeff_loader.sv
// Copies len words from system memory (src port, read-only) into the NTT
// accelerator data memory (dst port), one word at a time with a single
// outstanding transaction across both ports.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start_i; invalid lengths rejected with err_o
// S_RD_REQ  | read request for word idx held until src grant
// S_RD_WAIT | waiting for src rvalid; read data captured into buffer
// S_WR_REQ  | write request for word idx held until dst grant
// S_WR_WAIT | waiting for dst rvalid; word counted, abort/finish decided
// S_FIN     | one-cycle done_o pulse before returning to idle
module ntt_coeff_loader #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [LEN_W-1:0]  count_o,
    ntt_coeff_loader_if.master src,
    ntt_coeff_loader_if.master dst
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_FIN
    } state_e;

    state_e              state_q,    state_d;
    logic [ADDR_W-1:0]   src_base_q, src_base_d;
    logic [ADDR_W-1:0]   dst_base_q, dst_base_d;
    logic [LEN_W-1:0]    len_q,      len_d;
    // Words completed; doubles as the word index since both advance together.
    logic [LEN_W-1:0]    count_q,    count_d;
    logic [DATA_W-1:0]   buf_q,      buf_d;
    logic                abort_q,    abort_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                err_q,      err_d;
    logic                src_req_q,  src_req_d;
    logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
    logic                dst_req_q,  dst_req_d;
    logic [ADDR_W-1:0]   dst_addr_q, dst_addr_d;

    logic                len_bad;
    logic [LEN_W-1:0]    count_inc;

    assign len_bad   = (len_i == '0) || (32'(len_i) > 32'd256);
    assign count_inc = count_q + LEN_W'(1);

    // Next-state and next-output computation; port outputs are derived from
    // the next state so every bus output comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        len_d      = len_q;
        count_d    = count_q;
        buf_d      = buf_q;
        abort_d    = abort_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        src_base_d = src_addr_i;
                        dst_base_d = dst_addr_i;
                        len_d      = len_i;
                        count_d    = '0;
                        state_d    = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (src.gnt) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (src.rvalid) begin
                    buf_d   = src.rdata;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (dst.gnt) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (dst.rvalid) begin
                    count_d = count_inc;
                    // A same-cycle abort beats the final completion.
                    if (abort_q || abort_i) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (count_inc == len_q) begin
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE && abort_i) abort_d = 1'b1;
        if (state_d == S_IDLE)            abort_d = 1'b0;

        busy_d     = (state_d != S_IDLE);
        src_req_d  = (state_d == S_RD_REQ);
        dst_req_d  = (state_d == S_WR_REQ);
        src_addr_d = src_req_d ? src_base_d + (ADDR_W'(count_d) << 2) : '0;
        dst_addr_d = dst_req_d ? dst_base_d + (ADDR_W'(count_d) << 2) : '0;
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            src_base_q <= '0;
            dst_base_q <= '0;
            len_q      <= '0;
            count_q    <= '0;
            buf_q      <= '0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            src_req_q  <= 1'b0;
            src_addr_q <= '0;
            dst_req_q  <= 1'b0;
            dst_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
            len_q      <= len_d;
            count_q    <= count_d;
            buf_q      <= buf_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            src_req_q  <= src_req_d;
            src_addr_q <= src_addr_d;
            dst_req_q  <= dst_req_d;
            dst_addr_q <= dst_addr_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign count_o = count_q;

    assign src.req   = src_req_q;
    assign src.we    = 1'b0;
    assign src.be    = '0;
    assign src.addr  = src_addr_q;
    assign src.wdata = '0;

    // Write data is gated so the bus reads zero whenever no write is pending.
    assign dst.req   = dst_req_q;
    assign dst.we    = dst_req_q;
    assign dst.be    = {(DATA_W/8){dst_req_q}};
    assign dst.addr  = dst_addr_q;
    assign dst.wdata = dst_req_q ? buf_q : '0;

    // The accelerator port returns no read data on writes.
    logic unused_dst_rdata;
    assign unused_dst_rdata = ^dst.rdata;

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Self-checking bench: randomized-latency memory models on both ports,
// a transfer-level reference model and per-cycle bus protocol checks.
module tb_ntt_coeff_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] dst_a = '0;
    logic [8:0]  len = '0;
    logic        busy, done, err;
    logic [8:0]  count;

    ntt_coeff_loader_if #(.ADDR_W(32), .DATA_W(32)) src_bus ();
    ntt_coeff_loader_if #(.ADDR_W(32), .DATA_W(32)) dst_bus ();

    ntt_coeff_loader #(.ADDR_W(32), .DATA_W(32), .LEN_W(9)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .abort_i    (abort),
        .src_addr_i (src_a),
        .dst_addr_i (dst_a),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .count_o    (count),
        .src        (src_bus),
        .dst        (dst_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] src_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    int          maxdly = 0;
    int          done_cnt, err_cnt, busy_seen, req_seen;

    int          sph, sgd, srd, dph, dgd, drd;
    logic [31:0] s_hold;
    logic [68:0] d_hold;
    bit          s_resp, d_resp;

    // Memory models: grant after a random delay, respond at least one cycle
    // later, inject stray rvalids that the loader must ignore.
    always @(negedge clk) begin
        src_bus.gnt = 1'b0; src_bus.rvalid = 1'b0; src_bus.rdata = '0;
        dst_bus.gnt = 1'b0; dst_bus.rvalid = 1'b0; dst_bus.rdata = '0;
        if (rst) begin
            sph = 0;
            dph = 0;
        end else begin
            if (done) done_cnt++;
            if (err)  err_cnt++;
            if (busy) busy_seen++;
            if (src_bus.req || dst_bus.req) req_seen++;
            chk("one_req", {src_bus.req, dst_bus.req}, (src_bus.req ? 2'b10 : {1'b0, dst_bus.req}));
            if (!src_bus.req)
                chk("src_idle_zero", {src_bus.we, src_bus.be, src_bus.addr, src_bus.wdata}, 0);
            if (!dst_bus.req)
                chk("dst_idle_zero", {dst_bus.we, dst_bus.be, dst_bus.addr, dst_bus.wdata}, 0);

            s_resp = (sph == 2);
            if (sph == 2) begin
                if (srd == 0) begin
                    src_bus.rvalid = 1'b1;
                    src_bus.rdata  = src_word(s_hold);
                    sph = 0;
                end else srd--;
            end else begin
                if (sph == 0 && src_bus.req) begin
                    sph = 1; sgd = $urandom_range(maxdly, 0); s_hold = src_bus.addr;
                end
                if (sph == 1) begin
                    chk("src_hold", {src_bus.req, src_bus.we, src_bus.be, src_bus.wdata, src_bus.addr},
                        {1'b1, 1'b0, 4'h0, 32'h0, s_hold});
                    if (sgd == 0) begin
                        src_bus.gnt = 1'b1; rd_q.push_back(s_hold);
                        sph = 2; srd = $urandom_range(maxdly, 0);
                    end else sgd--;
                end
            end
            if (!s_resp && maxdly > 0 && $urandom_range(7, 0) == 0) begin
                src_bus.rvalid = 1'b1; src_bus.rdata = $urandom;
            end

            d_resp = (dph == 2);
            if (dph == 2) begin
                if (drd == 0) begin
                    dst_bus.rvalid = 1'b1; dph = 0;
                end else drd--;
            end else begin
                if (dph == 0 && dst_bus.req) begin
                    dph = 1; dgd = $urandom_range(maxdly, 0);
                    d_hold = {dst_bus.we, dst_bus.be, dst_bus.addr, dst_bus.wdata};
                end
                if (dph == 1) begin
                    chk("dst_hold", {dst_bus.req, dst_bus.we, dst_bus.be, dst_bus.addr, dst_bus.wdata},
                        {1'b1, 1'b1, 4'hF, d_hold[63:0]});
                    if (dgd == 0) begin
                        dst_bus.gnt = 1'b1;
                        wr_q.push_back('{a: d_hold[63:32], d: d_hold[31:0]});
                        dph = 2; drd = $urandom_range(maxdly, 0);
                    end else dgd--;
                end
            end
            if (!d_resp && maxdly > 0 && $urandom_range(7, 0) == 0) begin
                dst_bus.rvalid = 1'b1; dst_bus.rdata = $urandom;
            end
        end
    end

    // One transfer: reference is "words 0..k-1 copied, k = len or abort word+1".
    // exp_lat > 0 means zero-wait memories and a known done_o latency.
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int abort_w, input int exp_lat);
        int words;
        int c0, lat_done, first_req, budget;
        bit ab_done;
        logic [31:0] ea;
        words = (abort_w >= 0) ? abort_w + 1 : n;
        lat_done = -1; first_req = -1; budget = 0; ab_done = 0;
        wr_q.delete(); rd_q.delete(); done_cnt = 0; err_cnt = 0;
        @(negedge clk);
        start = 1'b1; src_a = s; dst_a = d; len = 9'(n); c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (1) begin
            start = 1'b0;
            abort = 1'b0;
            if (first_req < 0 && src_bus.req) first_req = cyc - c0;
            if (done && lat_done < 0) lat_done = cyc - c0;
            if (!busy) break;
            if (abort_w >= 0 && !ab_done && rd_q.size() == abort_w + 1) begin
                abort = 1'b1; ab_done = 1;
            end else if ($urandom_range(15, 0) == 0) begin
                start = 1'b1; len = 9'd0;
            end
            budget++;
            if (budget > 30 * n + 60) begin
                chk("xfer_timeout", 1, 0);
                rst = 1'b1; @(negedge clk); rst = 1'b0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        if (exp_lat > 0) begin
            chk("first_req_lat", first_req, 1);
            chk("done_lat", lat_done, exp_lat);
        end
        chk("done_pulses", done_cnt, (abort_w >= 0) ? 0 : 1);
        chk("err_pulses", err_cnt, (abort_w >= 0) ? 1 : 0);
        chk("count", count, words);
        chk("n_writes", wr_q.size(), words);
        chk("n_reads", rd_q.size(), words);
        for (int i = 0; i < words && i < wr_q.size(); i++) begin
            ea = d + 32'(i * 4);
            chk("wr_addr", wr_q[i].a, ea);
            ea = s + 32'(i * 4);
            chk("wr_data", wr_q[i].d, src_word(ea));
        end
        for (int i = 0; i < words && i < rd_q.size(); i++) begin
            ea = s + 32'(i * 4);
            chk("rd_addr", rd_q[i], ea);
        end
    endtask

    task automatic bad_start(input int n);
        logic [8:0] c_prev;
        c_prev = count;
        done_cnt = 0; err_cnt = 0; busy_seen = 0; req_seen = 0;
        @(negedge clk);
        start = 1'b1; len = 9'(n); src_a = 32'h5000; dst_a = 32'h6000;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("bad_err", err_cnt, 1);
        chk("bad_done", done_cnt, 0);
        chk("bad_busy", busy_seen, 0);
        chk("bad_port", req_seen, 0);
        chk("bad_count", count, c_prev);
    endtask

    initial begin
        int n, aw, w;
        logic [31:0] s, d;
        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, done, err, count, src_bus.req, src_bus.addr, dst_bus.req,
                           dst_bus.we, dst_bus.be, dst_bus.addr, dst_bus.wdata}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        maxdly = 0;
        run_xfer(32'h1000, 32'h0, 4, -1, 17);
        bad_start(0);
        bad_start(300);

        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        run_xfer(32'h2000, 32'h100, 3, -1, 13);
        run_xfer(32'hFFFF_FFF8, 32'h40, 4, -1, 17);
        run_xfer(32'h3000, 32'h200, 8, 2, 0);
        run_xfer(32'h3400, 32'h300, 5, 4, 0);

        maxdly = 5;
        run_xfer(32'h4000, 32'h800, 256, -1, 0);
        for (int k = 0; k < 6; k++) begin
            s  = $urandom & 32'hFFFF_FFFC;
            d  = $urandom & 32'hFFFF_FFFC;
            n  = $urandom_range(20, 1);
            aw = ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
            run_xfer(s, d, n, aw, 0);
        end

        maxdly = 0;
        done_cnt = 0; err_cnt = 0;
        @(negedge clk);
        start = 1'b1; len = 9'd8; src_a = 32'h7000; dst_a = 32'h7800;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!dst_bus.req && w < 100) begin
            @(negedge clk); w++;
        end
        chk("reach_wr_req", dst_bus.req, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", {busy, done, err, count, src_bus.req, src_bus.addr, dst_bus.req,
                             dst_bus.we, dst_bus.be, dst_bus.addr, dst_bus.wdata}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_pulse", {done_cnt[7:0], err_cnt[7:0]}, 0);
        run_xfer(32'h7100, 32'h7900, 6, -1, 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
